// File: rtl/pzcorebus_response_select_tracker.sv
// Response routing tracker: remembers which slave granted each non-posted command
// and presents the oldest outstanding grant as the response mux select.
module pzcorebus_response_select_tracker #(
  parameter int SLAVES = 2,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_command_valid,
  input  logic              i_command_accept,
  input  logic              i_command_non_posted,
  input  logic [SLAVES-1:0] i_command_grant,
  output logic              o_command_ready,
  input  logic              i_sresp_valid,
  input  logic              i_mresp_accept,
  input  logic              i_sresp_last,
  output logic [SLAVES-1:0] o_response_select,
  output logic              o_response_select_valid,
  output logic              o_unexpected_response
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SLAVES-1:0] r_entry [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_unexpected;

  logic w_ready;
  logic w_not_empty;
  logic w_np_accept;
  logic w_push;
  logic w_pop;
  logic w_error;

  // Ready comes from the count register alone, so a pop cannot open a slot in the same cycle.
  assign w_ready     = (r_count != CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_np_accept = i_command_valid & i_command_accept & i_command_non_posted;
  assign w_push      = w_np_accept & w_ready;
  assign w_pop       = i_sresp_valid & i_mresp_accept & i_sresp_last & w_not_empty;
  assign w_error     = (i_sresp_valid & ~w_not_empty) | (w_np_accept & ~w_ready);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_entry[r_wptr] <= i_command_grant;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_unexpected <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_error) begin
        r_unexpected <= 1'b1;
      end
    end
  end

  // Stale storage stays hidden while nothing is outstanding.
  assign o_response_select       = w_not_empty ? r_entry[r_rptr] : '0;
  assign o_response_select_valid = w_not_empty;
  assign o_command_ready         = w_ready;
  assign o_unexpected_response   = r_unexpected;

endmodule

// File: tb/tb_pzcorebus_response_select_tracker.sv
// Scoreboard bench: a queue-based reference tracks outstanding grants; a monitor
// compares every registered output each cycle against the expected values.
module tb_pzcorebus_response_select_tracker;

  localparam int SLAVES = 4;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_accept, cmd_np;
  logic [SLAVES-1:0] cmd_grant;
  logic              cmd_ready;
  logic              sresp_valid, mresp_accept, sresp_last;
  logic [SLAVES-1:0] resp_sel;
  logic              resp_sel_valid;
  logic              unexpected;

  always #5 clk = ~clk;

  pzcorebus_response_select_tracker #(.SLAVES(SLAVES), .DEPTH(DEPTH)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_command_valid        (cmd_valid),
    .i_command_accept       (cmd_accept),
    .i_command_non_posted   (cmd_np),
    .i_command_grant        (cmd_grant),
    .o_command_ready        (cmd_ready),
    .i_sresp_valid          (sresp_valid),
    .i_mresp_accept         (mresp_accept),
    .i_sresp_last           (sresp_last),
    .o_response_select      (resp_sel),
    .o_response_select_valid(resp_sel_valid),
    .o_unexpected_response  (unexpected)
  );

  typedef struct {
    logic [SLAVES-1:0] sel;
    logic              valid;
    logic              ready;
    logic              flag;
    int                cyc;
  } exp_t;

  exp_t              exp_q[$];
  logic [SLAVES-1:0] model_q[$];
  logic              model_flag = 1'b0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc = 0;

  task automatic check(input string name, input int act, input int req, input int c);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  // Monitor: one line per cycle transaction, comparing all outputs to the scoreboard entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("select",       int'(resp_sel),       int'(e.sel),   e.cyc);
      check("select_valid", int'(resp_sel_valid), int'(e.valid), e.cyc);
      check("cmd_ready",    int'(cmd_ready),      int'(e.ready), e.cyc);
      check("unexpected",   int'(unexpected),     int'(e.flag),  e.cyc);
      $display("cyc=%0d sel=%b valid=%b ready=%b flag=%b", e.cyc, resp_sel, resp_sel_valid,
               cmd_ready, unexpected);
    end
  end

  // Drive one cycle, advance the reference from its pre-edge state, and queue the expectation.
  task automatic step(input logic r, input logic v, input logic a, input logic np,
                      input logic [SLAVES-1:0] g, input logic sv, input logic ma,
                      input logic last);
    int   occ;
    logic push, pop, err;
    exp_t e;
    rst = r; cmd_valid = v; cmd_accept = a; cmd_np = np; cmd_grant = g;
    sresp_valid = sv; mresp_accept = ma; sresp_last = last;
    occ  = model_q.size();
    push = v && a && np && (occ < DEPTH);
    pop  = sv && ma && last && (occ > 0);
    err  = (sv && occ == 0) || (v && a && np && occ >= DEPTH);
    @(posedge clk);
    cyc++;
    if (r) begin
      model_q.delete();
      model_flag = 1'b0;
    end else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(g);
      if (err)  model_flag = 1'b1;
    end
    e.sel   = (model_q.size() > 0) ? model_q[0] : '0;
    e.valid = (model_q.size() > 0);
    e.ready = (model_q.size() < DEPTH);
    e.flag  = model_flag;
    e.cyc   = cyc;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic push_cmd(input logic [SLAVES-1:0] g);
    step(0, 1, 1, 1, g, 0, 0, 0);
  endtask

  task automatic pop_resp();
    step(0, 0, 0, 0, '0, 1, 1, 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, '0, 0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0, 0);
    idle();

    // In-order routing
    push_cmd(4'b0001); push_cmd(4'b0100); push_cmd(4'b0010);
    pop_resp(); pop_resp(); pop_resp();
    idle();

    // Full, then a push attempt alongside a pop, then wrap with two more pushes
    push_cmd(4'b1000); push_cmd(4'b0001); push_cmd(4'b0010);
    step(0, 1, 1, 1, 4'b0100, 1, 1, 1);
    push_cmd(4'b0100); push_cmd(4'b1000);
    pop_resp(); pop_resp(); pop_resp();
    idle();

    // Multi-beat response pops only on the last beat
    push_cmd(4'b0010);
    for (int b = 0; b < 4; b++) step(0, 0, 0, 0, '0, 1, 1, (b == 3));
    idle();

    // Simultaneous push and pop at occupancy one
    push_cmd(4'b0001);
    step(0, 1, 1, 1, 4'b1000, 1, 1, 1);
    pop_resp();

    // Posted commands are ignored; a response with nothing outstanding raises the flag
    step(0, 1, 1, 0, 4'b0100, 0, 0, 0);
    push_cmd(4'b0010);
    step(0, 1, 1, 0, 4'b1000, 0, 0, 0);
    pop_resp();
    step(0, 0, 0, 0, '0, 1, 1, 1);
    idle(); idle();

    // Reset with two outstanding entries, then a stray response
    step(1, 0, 0, 0, '0, 0, 0, 0);
    push_cmd(4'b0100); push_cmd(4'b0001);
    step(1, 0, 0, 0, '0, 0, 0, 0);
    idle();
    pop_resp();
    step(1, 0, 0, 0, '0, 0, 0, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [SLAVES-1:0] g;
      g = SLAVES'(1) << $urandom_range(0, SLAVES - 1);
      step(($urandom_range(0, 99) == 0),
           $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, g,
           $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pzcorebus_response_select_tracker.md
PZCOREBUS_RESPONSE_SELECT_TRACKER -- requirements
Module: pzcorebus_response_select_tracker

Interface
REQ-001 Parameter SLAVES, default 2, number of upstream slave ports; legal range 2..32.
REQ-002 Parameter DEPTH, default 4, maximum outstanding non-posted commands tracked; legal range 1..64, need not be a power of 2.
REQ-003 i_clk  input  1  clock; single clock domain, all state updates on the rising edge.
REQ-004 i_rst  input  1  reset; synchronous and active-high.
REQ-005 i_command_valid  input  1  arbitrated command valid on the master side.
REQ-006 i_command_accept  input  1  master-side command accept.
REQ-007 i_command_non_posted  input  1  command expects a response.
REQ-008 i_command_grant  input  SLAVES  onehot index of the granting slave, qualified by i_command_valid.
REQ-009 o_command_ready  output  1  tracker can record one more non-posted command.
REQ-010 i_sresp_valid  input  1  master-side response valid.
REQ-011 i_mresp_accept  input  1  master-side response accept.
REQ-012 i_sresp_last  input  1  final beat of the current response.
REQ-013 o_response_select  output  SLAVES  onehot select driving the response mux.
REQ-014 o_response_select_valid  output  1  o_response_select holds a tracked entry.
REQ-015 o_unexpected_response  output  1  sticky error flag.

Function
REQ-016 Push: on i_command_valid & i_command_accept & i_command_non_posted & o_command_ready, i_command_grant SHALL be written at the write pointer, and the pointer SHALL advance.
REQ-017 Posted commands (i_command_non_posted=0) SHALL NOT push.
REQ-018 Pop: on i_sresp_valid & i_mresp_accept & i_sresp_last & o_response_select_valid, the read pointer SHALL advance. Non-last beats SHALL NOT pop.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 The occupancy count is clog2(DEPTH+1) bits. It SHALL update by +1 on push only, -1 on pop only, and 0 when push and pop occur in the same cycle.
REQ-021 o_command_ready SHALL be !(count==DEPTH). It SHALL be registered-derived only, with no combinational path from the response inputs. When full, a same-cycle pop SHALL NOT allow a same-cycle push.
REQ-022 The upstream arbiter SHALL gate i_command_accept with o_command_ready for non-posted commands. A non-posted accept while o_command_ready=0 SHALL be dropped and SHALL set o_unexpected_response.
REQ-023 o_response_select SHALL equal the head entry when count>0, and all-zero when count==0.
REQ-024 o_response_select_valid SHALL be (count>0).
REQ-025 Push-to-select latency is 1 cycle: an entry written at edge N is visible at the head after edge N when the FIFO was empty. There is no bypass.
REQ-026 o_unexpected_response SHALL set on i_sresp_valid while count==0, and SHALL stay set until reset.
REQ-027 Outputs SHALL depend only on registers; i_command_grant is not checked for onehot.

Reset
REQ-028 While i_rst=1 at an edge, the following SHALL hold:
- pointers and count cleared
- o_command_ready=1
- o_response_select='0
- o_response_select_valid=0
- o_unexpected_response=0
REQ-029 Reset mid-operation SHALL discard all outstanding entries. Responses arriving after reset with count==0 SHALL set o_unexpected_response.
REQ-030 The storage array needs no reset; it SHALL NOT be observable when count==0.

Verification
REQ-031 Basic order (SLAVES=4, DEPTH=4):
- stimulus: push grants 0001, 0100, 0010; then three single-beat last responses
- response: o_response_select sequence 0001, 0100, 0010; valid drops after the third pop.
REQ-032 Full/wrap (DEPTH=3):
- stimulus: push 3 entries; attempt a 4th with a same-cycle pop
- response: o_command_ready=0 throughout that cycle; count=2 after the cycle
- then push 2 more; check pointer wrap and correct order.
REQ-033 Multi-beat response:
- stimulus: head=0010, 4-beat response with i_sresp_last only on beat 4
- response: select stays 0010 for all beats; pops only after beat 4.
REQ-034 Simultaneous push/pop at count=1:
- response: count stays 1; head becomes the new entry next cycle.
REQ-035 Posted filter and error:
- stimulus: posted commands interleaved with non-posted ones
- response: no entries recorded for posted commands
- response with count==0: o_unexpected_response=1 until i_rst.
REQ-036 Reset mid-stream:
- stimulus: assert i_rst with count=2
- response: the next cycle shows count=0, select='0, ready=1, flag=0.
